// File: rtl/key_map_pkg.sv
// Shared scancode constants and widths for the keyboard-to-action mapper.
package key_map_pkg;

    localparam int unsigned SCAN_W   = 9;
    localparam int unsigned KEYVEC_W = 512;

    localparam logic [SCAN_W-1:0] KEY_A     = 9'h01c;
    localparam logic [SCAN_W-1:0] KEY_D     = 9'h023;
    localparam logic [SCAN_W-1:0] KEY_W     = 9'h01d;
    localparam logic [SCAN_W-1:0] KEY_SPACE = 9'h029;

    // Channel 0 sits in the low bits: 0=A, 1=D, 2=W, 3=Space.
    localparam logic [4*SCAN_W-1:0] DEFAULT_KEY_CODES = {KEY_SPACE, KEY_W, KEY_D, KEY_A};

endpackage

// File: rtl/key_action_map_if.sv
// Decoder-side inputs and per-channel action outputs of key_action_map.
interface key_action_map_if
    import key_map_pkg::*;
#(
    parameter int unsigned N_KEYS = 4,
    parameter int unsigned IDX_W  = 4
);
    logic                  key_valid;
    logic [SCAN_W-1:0]     last_change;
    logic [KEYVEC_W-1:0]   key_down;
    logic [N_KEYS-1:0]     held;
    logic [N_KEYS-1:0]     press;
    logic [N_KEYS-1:0]     release_pulse;
    logic [N_KEYS-1:0]     action;
    logic                  newest_valid;
    logic [IDX_W-1:0]      newest_idx;

    modport master (
        output key_valid, last_change, key_down,
        input  held, press, release_pulse, action, newest_valid, newest_idx
    );

    modport slave (
        input  key_valid, last_change, key_down,
        output held, press, release_pulse, action, newest_valid, newest_idx
    );
endinterface

// File: rtl/key_repeat_timer.sv
// Per-channel typematic timer: rep_pulse is the channel's action pulse,
// asserted on start and then after REPEAT_DELAY and every REPEAT_RATE cycles.
module key_repeat_timer #(
    parameter int unsigned REPEAT_DELAY = 25_000_000,
    parameter int unsigned REPEAT_RATE  = 5_000_000,
    parameter int unsigned CNT_W        = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic stop,
    input  logic held,
    output logic rep_pulse
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pulse_d;

    // Stop beats a repeat landing on the same cycle.
    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (stop) begin
            cnt_d = '0;
        end else if (start) begin
            cnt_d   = CNT_W'(REPEAT_DELAY);
            pulse_d = 1'b1;
        end else if (held && (cnt_q != '0)) begin
            if (cnt_q == CNT_W'(1)) begin
                cnt_d   = CNT_W'(REPEAT_RATE);
                pulse_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            rep_pulse <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rep_pulse <= pulse_d;
        end
    end
endmodule

// File: rtl/key_action_map.sv
// N-channel scancode-to-action mapper with held/press/release/action and newest-held tracking.
// Define KEY_REPEAT_EN to add typematic auto-repeat on action; otherwise action mirrors press.
module key_action_map
    import key_map_pkg::*;
#(
    parameter int unsigned                N_KEYS       = 4,
    parameter logic [N_KEYS*SCAN_W-1:0]   KEY_CODES    = DEFAULT_KEY_CODES,
    parameter int unsigned                REPEAT_DELAY = 25_000_000,
    parameter int unsigned                REPEAT_RATE  = 5_000_000,
    parameter int unsigned                CNT_W        = 25,
    parameter int unsigned                IDX_W        = 4
) (
    input  logic           clk,
    input  logic           rst,
    key_action_map_if.slave bus
);
    logic                down_c;
    logic [N_KEYS-1:0]   match_c;
    logic [N_KEYS-1:0]   make_c;
    logic [N_KEYS-1:0]   brk_c;

    logic [N_KEYS-1:0]   held_q;
    logic [N_KEYS-1:0]   press_q;
    logic [N_KEYS-1:0]   rel_q;
    logic [N_KEYS-1:0]   action_q;
    logic                newest_valid_q;
    logic                newest_valid_d;
    logic [IDX_W-1:0]    newest_idx_q;
    logic [IDX_W-1:0]    newest_idx_d;

    // Decode the strobe; re-makes of a held key and breaks of an idle key are dropped.
    always_comb begin
        down_c  = bus.key_down[bus.last_change];
        match_c = '0;
        make_c  = '0;
        brk_c   = '0;
        for (int i = 0; i < int'(N_KEYS); i++) begin
            match_c[i] = bus.key_valid && (bus.last_change == KEY_CODES[i*SCAN_W +: SCAN_W]);
            make_c[i]  = match_c[i] && down_c && !held_q[i];
            brk_c[i]   = match_c[i] && !down_c && held_q[i];
        end
    end

    // Last pressed wins; releasing the newest key invalidates without re-deriving.
    always_comb begin
        newest_valid_d = newest_valid_q;
        newest_idx_d   = newest_idx_q;
        for (int i = 0; i < int'(N_KEYS); i++) begin
            if (brk_c[i] && (newest_idx_q == IDX_W'(i))) newest_valid_d = 1'b0;
        end
        for (int i = 0; i < int'(N_KEYS); i++) begin
            if (make_c[i]) begin
                newest_valid_d = 1'b1;
                newest_idx_d   = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_q         <= '0;
            press_q        <= '0;
            rel_q          <= '0;
            newest_valid_q <= 1'b0;
            newest_idx_q   <= '0;
        end else begin
            held_q         <= (held_q | make_c) & ~brk_c;
            press_q        <= make_c;
            rel_q          <= brk_c;
            newest_valid_q <= newest_valid_d;
            newest_idx_q   <= newest_idx_d;
        end
    end

`ifdef KEY_REPEAT_EN
    for (genvar i = 0; i < int'(N_KEYS); i++) begin : g_timer
        key_repeat_timer #(
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE),
            .CNT_W        (CNT_W)
        ) u_timer (
            .clk       (clk),
            .rst       (rst),
            .start     (make_c[i]),
            .stop      (brk_c[i]),
            .held      (held_q[i]),
            .rep_pulse (action_q[i])
        );
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{REPEAT_DELAY, REPEAT_RATE, CNT_W};

    always_ff @(posedge clk) begin
        if (rst) action_q <= '0;
        else     action_q <= make_c;
    end
`endif

    assign bus.held          = held_q;
    assign bus.press         = press_q;
    assign bus.release_pulse = rel_q;
    assign bus.action        = action_q;
    assign bus.newest_valid  = newest_valid_q;
    assign bus.newest_idx    = newest_idx_q;
endmodule

// File: tb/tb_key_action_map.sv
// Directed scoreboard bench for key_action_map with tiny repeat timing (delay 8, rate 3).
module tb_key_action_map;
    import key_map_pkg::*;

    localparam int unsigned DLY  = 8;
    localparam int unsigned RATE = 3;

    typedef struct {
        logic [3:0] held;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] act;
        logic       nv;
        logic [3:0] ni;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    logic [3:0] eh;
    logic       env;
    logic [3:0] eni;

    key_action_map_if #(.N_KEYS(4), .IDX_W(4)) bus ();

    key_action_map #(
        .N_KEYS       (4),
        .KEY_CODES    (DEFAULT_KEY_CODES),
        .REPEAT_DELAY (DLY),
        .REPEAT_RATE  (RATE),
        .CNT_W        (4),
        .IDX_W        (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Expected repeat on A when A's press pulse was output cycle 1.
    function automatic logic a_rep(input int k);
`ifdef KEY_REPEAT_EN
        return (k >= int'(DLY) + 1) && (((k - int'(DLY) - 1) % int'(RATE)) == 0);
`else
        return (k < 0);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue the expected response, compare after the edge.
    task automatic step(input logic kv, input logic [8:0] code, input logic dn,
                        input logic [3:0] p, input logic [3:0] r, input logic [3:0] a,
                        input string tag);
        exp_t e;
        bus.key_valid   = kv;
        bus.last_change = code;
        if (kv) bus.key_down[code] = dn;
        sb.push_back('{held: eh, press: p, rel: r, act: a, nv: env, ni: eni, tag: tag});
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
        e = sb.pop_front();
        chk({e.tag, ".held"},    32'(bus.held),          32'(e.held));
        chk({e.tag, ".press"},   32'(bus.press),         32'(e.press));
        chk({e.tag, ".release"}, 32'(bus.release_pulse), 32'(e.rel));
        chk({e.tag, ".action"},  32'(bus.action),        32'(e.act));
        chk({e.tag, ".nvalid"},  32'(bus.newest_valid),  32'(e.nv));
        chk({e.tag, ".nidx"},    32'(bus.newest_idx),    32'(e.ni));
    endtask

    initial begin
        rst             = 1'b1;
        bus.key_valid   = 1'b0;
        bus.last_change = '0;
        bus.key_down    = '0;
        eh = '0; env = 1'b0; eni = '0;

        for (int i = 0; i < 3; i++) step(1'(i % 2), KEY_A, 1'b1, 4'h0, 4'h0, 4'h0, "reset");
        rst = 1'b0;
        step(1'b0, 9'h000, 1'b0, 4'h0, 4'h0, 4'h0, "post_reset");

        // Hold A for 20 cycles, re-sending its make mid-way.
        eh = 4'b0001; env = 1'b1; eni = 4'd0;
        step(1'b1, KEY_A, 1'b1, 4'b0001, 4'h0, 4'b0001, "make_a");
        for (int k = 2; k <= 20; k++)
            step(k == 6, KEY_A, 1'b1, 4'h0, 4'h0, {3'b000, a_rep(k)}, "hold_a");
        eh = 4'b0000; env = 1'b0;
        step(1'b1, KEY_A, 1'b0, 4'h0, 4'b0001, 4'h0, "break_on_repeat");
        for (int k = 0; k < 5; k++) step(1'b0, 9'h000, 1'b0, 4'h0, 4'h0, 4'h0, "idle_after_break");

        // A then D, break D; ignored events while A keeps repeating.
        eh = 4'b0001; env = 1'b1; eni = 4'd0;
        step(1'b1, KEY_A, 1'b1, 4'b0001, 4'h0, 4'b0001, "make_a2");
        for (int k = 2; k <= 4; k++) step(1'b0, 9'h000, 1'b0, 4'h0, 4'h0, {3'b000, a_rep(k)}, "hold_a2");
        eh = 4'b0011; eni = 4'd1;
        step(1'b1, KEY_D, 1'b1, 4'b0010, 4'h0, 4'b0010 | {3'b000, a_rep(5)}, "make_d");
        for (int k = 6; k <= 10; k++) step(1'b0, 9'h000, 1'b0, 4'h0, 4'h0, {3'b000, a_rep(k)}, "hold_ad");
        eh = 4'b0001; env = 1'b0;
        step(1'b1, KEY_D, 1'b0, 4'h0, 4'b0010, {3'b000, a_rep(11)}, "break_d");
        step(1'b0, 9'h000, 1'b0, 4'h0, 4'h0, {3'b000, a_rep(12)}, "hold_a3");
        step(1'b1, KEY_D, 1'b0, 4'h0, 4'h0, {3'b000, a_rep(13)}, "break_unheld");
        step(1'b1, 9'h015, 1'b1, 4'h0, 4'h0, {3'b000, a_rep(14)}, "unmapped");
        step(1'b0, 9'h000, 1'b0, 4'h0, 4'h0, {3'b000, a_rep(15)}, "hold_a4");
        eh = 4'b0000;
        step(1'b1, KEY_A, 1'b0, 4'h0, 4'b0001, 4'h0, "break_a");
        for (int k = 0; k < 2; k++) step(1'b0, 9'h000, 1'b0, 4'h0, 4'h0, 4'h0, "idle2");

        // Releasing a non-newest key keeps newest valid.
        eh = 4'b0010; env = 1'b1; eni = 4'd1;
        step(1'b1, KEY_D, 1'b1, 4'b0010, 4'h0, 4'b0010, "make_d2");
        eh = 4'b0011; eni = 4'd0;
        step(1'b1, KEY_A, 1'b1, 4'b0001, 4'h0, 4'b0001, "make_a_newest");
        eh = 4'b0001;
        step(1'b1, KEY_D, 1'b0, 4'h0, 4'b0010, 4'h0, "break_old_d");
        eh = 4'b0000; env = 1'b0;
        step(1'b1, KEY_A, 1'b0, 4'h0, 4'b0001, 4'h0, "break_newest_a");

        // Reset while A is held; no press until a fresh make.
        eh = 4'b0001; env = 1'b1; eni = 4'd0;
        step(1'b1, KEY_A, 1'b1, 4'b0001, 4'h0, 4'b0001, "make_a3");
        rst = 1'b1; eh = 4'b0000; env = 1'b0; eni = 4'd0;
        step(1'b0, 9'h000, 1'b0, 4'h0, 4'h0, 4'h0, "reset_mid_hold");
        rst = 1'b0;
        step(1'b0, 9'h000, 1'b0, 4'h0, 4'h0, 4'h0, "no_press_after_reset");
        eh = 4'b0001; env = 1'b1;
        step(1'b1, KEY_A, 1'b1, 4'b0001, 4'h0, 4'b0001, "remake_after_reset");
        eh = 4'b0000; env = 1'b0;
        step(1'b1, KEY_A, 1'b0, 4'h0, 4'b0001, 4'h0, "final_break");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/key_action_map.md
Name: key_action_map

Overview:
- Parametrised keyboard-to-action mapper between KeyboardDecoder and the game logic (slime_move and successors).
- Replaces the fixed two-key A/D mapper with N configurable scancode channels.
- Per channel: held level, press/release pulses, and a typematic-style auto-repeat action pulse.
- Also tracks the most recently pressed held channel, so opposing directions resolve as "last pressed wins".

Parameters:
- N_KEYS, 4, number of action channels (1..16).
- KEY_CODES, {9'h029, 9'h01d, 9'h023, 9'h01c}, packed N_KEYS*9 scancodes; channel i = bits [9i+8:9i]. Defaults: 0=A, 1=D, 2=W, 3=Space.
- REPEAT_DELAY, 25_000_000, cycles from press to first repeat pulse (must be >=1).
- REPEAT_RATE, 5_000_000, cycles between subsequent repeat pulses (must be >=1).
- CNT_W, 25, repeat counter width; must hold max(REPEAT_DELAY, REPEAT_RATE).
- IDX_W, 4, width of newest_idx.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous active-high reset.
- key_valid  in  1  one-cycle strobe from KeyboardDecoder; last_change updated.
- last_change  in  9  scancode of latest make/break.
- key_down  in  512  KeyboardDecoder key-state vector.
- held  out  N_KEYS  level; channel key currently down.
- press  out  N_KEYS  1-cycle pulse on make.
- release  out  N_KEYS  1-cycle pulse on break.
- action  out  N_KEYS  1-cycle pulse on press or repeat.
- newest_valid  out  1  newest_idx refers to a held channel.
- newest_idx  out  IDX_W  most recently pressed channel still held.

Behaviour:
- Decided: one clock; reset is synchronous and active-high. Ports are named clk and rst.
- All outputs are registered.
- Reset values: held=0, press=0, release=0, action=0, newest_valid=0, newest_idx=0, all repeat counters=0.
- Decode happens in the cycle key_valid=1; responses appear on the next clk edge (latency 1). Pulses last exactly 1 cycle.
- Make event (key_valid, last_change==KEY_CODES[i], key_down[last_change]=1, held[i]=0):
  - held[i]<=1, press[i]<=1, action[i]<=1.
  - counter[i]<=REPEAT_DELAY.
  - newest_idx<=i, newest_valid<=1.
- Typematic re-make (same conditions but held[i]=1): ignored. No pulse; counter not reloaded.
- Break event (key_valid, code match, key_down[last_change]=0):
  - If held[i]=1: held[i]<=0, release[i]<=1, counter[i]<=0.
  - If held[i]=0: no effect.
  - If newest_idx==i: newest_valid<=0. Newest is not re-derived from other held keys.
- Repeat, while held[i]=1 and counter[i]!=0:
  - counter decrements each cycle.
  - The cycle it would reach 0: action[i]<=1 and counter[i]<=REPEAT_RATE.
  - First repeat therefore fires REPEAT_DELAY cycles after the press pulse; later repeats every REPEAT_RATE cycles.
- Unmapped scancode: no effect on any output.
- Duplicate entries in KEY_CODES: every matching channel responds independently. If several match on one make, newest_idx takes the highest matching index.
- Only one event per key_valid strobe, so simultaneous make/break on different channels cannot occur.
- A repeat pulse coinciding with a break on the same channel is suppressed: break wins, action=0.
- Reset mid-hold: all state cleared. A key still physically down yields no press until its next make event.

Optional Feature:
- KEY_REPEAT_EN defined: repeat counters are instantiated and behave as specified above.
- KEY_REPEAT_EN undefined:
  - No counters synthesised; CNT_W, REPEAT_DELAY and REPEAT_RATE are unused.
  - action is identical to press.

Decomposition:
- Package key_map_pkg holds:
  - scancode constants KEY_A=9'h01c, KEY_D=9'h023, KEY_W=9'h01d, KEY_SPACE=9'h029;
  - SCAN_W=9 and KEYVEC_W=512;
  - default KEY_CODES vector.
- Natural sub-module: key_repeat_timer, one per channel, generated only under KEY_REPEAT_EN.
  - Inputs: clk, rst, start, stop, held.
  - Output: rep_pulse.
  - Parameters: REPEAT_DELAY, REPEAT_RATE, CNT_W.

Test Plan:
- Tiny-timing build: N_KEYS=4, REPEAT_DELAY=8, REPEAT_RATE=3.
- Reset: hold rst 3 cycles with key_valid toggling -> all outputs 0; newest_valid=0 one cycle after rst falls.
- Make A (key_valid, last_change=9'h01c, key_down[9'h01c]=1) at cycle T -> press[0]=action[0]=1 at T+1 only; held[0]=1; newest_idx=0, newest_valid=1.
- Keep A held 20 cycles under KEY_REPEAT_EN -> action[0] pulses at T+9, T+12, T+15, T+18; also re-send the A make at T+5 -> no extra pulse, repeat schedule unchanged.
- Press A at T, D at T+4, then break D at T+10 -> newest_idx=1 at T+5; newest_valid=0 at T+11; held=4'b0001; release[1]=1 at T+11.
- Break of unheld key (last_change=9'h023, key_down bit 0) and make of unmapped 9'h015 -> no output change.
- Break A on the exact cycle its repeat would fire -> release[0]=1, action[0]=0; with KEY_REPEAT_EN undefined, same held-A stimulus -> a single action pulse only.
